// File: rtl/store_buffer_unit.sv
// Store buffer: circular FIFO of committed stores, drained as byte-lane write beats.
// A store that crosses a word boundary is issued as two beats, or rejected if splitting is off.
module store_buffer_unit #(
  parameter int XLEN           = 32,
  parameter int DEPTH          = 4,
  parameter int MISALIGN_SPLIT = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [2:0]                 req_func3,
  input  logic [XLEN-1:0]            req_addr,
  input  logic [XLEN-1:0]            req_data,
  output logic                       mem_valid,
  input  logic                       mem_ready,
  output logic [XLEN-1:0]            mem_addr,
  output logic [XLEN-1:0]            mem_wdata,
  output logic [XLEN/8-1:0]          mem_wmask,
  output logic                       req_err,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int BYTES = XLEN / 8;
  localparam int OFS   = $clog2(BYTES);
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;
  localparam int MW    = 2 * BYTES;
  localparam int DW    = 2 * XLEN;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   head, tail;
  logic [CW-1:0]   count_nxt;

  logic [XLEN-1:0] addr_q [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [1:0]      fn_q   [DEPTH];

  // Request decode
  logic [OFS-1:0]  req_off;
  logic [3:0]      req_size;
  logic [4:0]      req_end;
  logic            illegal, accept, push, pop;

  assign req_off  = req_addr[OFS-1:0];
  assign req_size = 4'd1 << req_func3[1:0];
  assign req_end  = {1'b0, req_size} + 5'(req_off);
  assign illegal  = req_func3[2]
                  | ((XLEN == 32) && (req_func3[1:0] == 2'b11))
                  | ((MISALIGN_SPLIT == 0) && (req_end > 5'(BYTES)));

  // Ready depends on registered occupancy only, so a same-cycle drain never opens a slot.
  assign req_ready = (count != CW'(DEPTH));
  assign accept    = req_valid & req_ready;
  assign push      = accept & ~illegal;
  assign empty     = (count == '0);

  // Head-entry lane arithmetic; head is stable while a beat is stalled.
  logic [XLEN-1:0] h_addr, h_data, base_addr;
  logic [1:0]      h_fn;
  logic [OFS-1:0]  h_off;
  logic [3:0]      h_size;
  logic [MW-1:0]   mask_base, smask;
  logic [DW-1:0]   ext, sdata;
  logic            has_beat1, last_beat;

  assign h_addr    = addr_q[head];
  assign h_data    = data_q[head];
  assign h_fn      = fn_q[head];
  assign h_off     = h_addr[OFS-1:0];
  assign h_size    = 4'd1 << h_fn;
  assign mask_base = (MW'(1) << h_size) - MW'(1);
  assign smask     = mask_base << h_off;

  for (genvar i = 0; i < BYTES; i++) begin : g_lane
    assign ext[8*i +: 8] = mask_base[i] ? h_data[8*i +: 8] : 8'h00;
  end
  assign ext[DW-1:XLEN] = '0;

  assign sdata     = ext << {h_off, 3'b000};
  assign has_beat1 = |smask[MW-1:BYTES];
  assign base_addr = {h_addr[XLEN-1:OFS], {OFS{1'b0}}};

  assign mem_valid = (state != IDLE);
  assign mem_addr  = (state == BEAT1) ? base_addr + XLEN'(BYTES) : base_addr;
  assign mem_wdata = (state == BEAT1) ? sdata[DW-1:XLEN] : sdata[XLEN-1:0];
  assign mem_wmask = (state == BEAT1) ? smask[MW-1:BYTES] : smask[BYTES-1:0];

  assign last_beat = (state == BEAT1) | ((state == BEAT0) & ~has_beat1);
  assign pop       = mem_valid & mem_ready & last_beat;
  assign count_nxt = count + CW'(push) - CW'(pop);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (count != '0) state_nxt = BEAT0;
      BEAT0: if (mem_ready) begin
               if (has_beat1)             state_nxt = BEAT1;
               else if (count_nxt != '0)  state_nxt = BEAT0;
               else                       state_nxt = IDLE;
             end
      BEAT1: if (mem_ready) state_nxt = (count_nxt != '0) ? BEAT0 : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      count   <= '0;
      head    <= '0;
      tail    <= '0;
      req_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      req_err <= accept & illegal;
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= req_addr;
      data_q[tail] <= req_data;
      fn_q[tail]   <= req_func3[1:0];
    end
  end
endmodule

// File: tb/tb_store_buffer_unit.sv
// Directed bench for store_buffer_unit: default instance plus a no-split instance.
module tb_store_buffer_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_valid_b;
  logic [2:0]  req_func3;
  logic [31:0] req_addr, req_data;
  logic        mem_ready, mem_ready_b;

  logic        req_ready, mem_valid, req_err, empty;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic [2:0]  count;

  logic        req_ready_b, mem_valid_b, req_err_b, empty_b;
  logic [31:0] mem_addr_b, mem_wdata_b;
  logic [3:0]  mem_wmask_b;
  logic [2:0]  count_b;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  store_buffer_unit #(.XLEN(32), .DEPTH(4), .MISALIGN_SPLIT(1)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_func3(req_func3),
    .req_addr(req_addr), .req_data(req_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .req_err(req_err), .empty(empty), .count(count)
  );

  store_buffer_unit #(.XLEN(32), .DEPTH(4), .MISALIGN_SPLIT(0)) u_dut_ns (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_func3(req_func3),
    .req_addr(req_addr), .req_data(req_data),
    .mem_valid(mem_valid_b), .mem_ready(mem_ready_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_wmask(mem_wmask_b),
    .req_err(req_err_b), .empty(empty_b), .count(count_b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1; req_func3 = f; req_addr = a; req_data = d;
    tick;
    req_valid = 1'b0;
  endtask

  task automatic send_b(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    req_valid_b = 1'b1; req_func3 = f; req_addr = a; req_data = d;
    tick;
    req_valid_b = 1'b0;
  endtask

  // Waits at most maxw cycles for a beat, checks it, then advances one edge.
  task automatic expect_beat(input string tag, input int maxw,
                             input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    int w = 0;
    while (!mem_valid && w < maxw) begin
      tick;
      w++;
    end
    chk({tag, ".valid"}, mem_valid, 1);
    chk({tag, ".addr"},  mem_addr,  a);
    chk({tag, ".wdata"}, mem_wdata, d);
    chk({tag, ".wmask"}, mem_wmask, m);
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int acc;
    rst = 1'b0; req_valid = 1'b0; req_valid_b = 1'b0;
    req_func3 = 3'b000; req_addr = '0; req_data = '0;
    mem_ready = 1'b0; mem_ready_b = 1'b1;
    tick; tick;
    chk("rst.count", count, 0);
    chk("rst.empty", empty, 1);
    chk("rst.mem_valid", mem_valid, 0);
    chk("rst.req_ready", req_ready, 1);
    chk("rst.req_err", req_err, 0);
    rst = 1'b1;
    tick;

    // Single byte store, beat must appear one cycle after acceptance
    mem_ready = 1'b1;
    send(3'b000, 32'h0000_1003, 32'hAABB_CCDD);
    chk("sb.count", count, 1);
    expect_beat("sb", 1, 32'h0000_1000, 32'hDD00_0000, 4'b1000);
    chk("sb.done_valid", mem_valid, 0);
    chk("sb.empty", empty, 1);

    // Halfword crossing a word boundary
    send(3'b001, 32'h0000_2003, 32'h0000_1234);
    expect_beat("sh_b0", 1, 32'h0000_2000, 32'h3400_0000, 4'b1000);
    expect_beat("sh_b1", 0, 32'h0000_2004, 32'h0000_0012, 4'b0001);
    chk("sh.empty", empty, 1);

    // Split word with three stalled cycles on beat 0
    mem_ready = 1'b0;
    send(3'b010, 32'h0000_3002, 32'h1122_3344);
    expect_beat("sw_b0", 1, 32'h0000_3000, 32'h3344_0000, 4'b1100);
    expect_beat("sw_hold1", 0, 32'h0000_3000, 32'h3344_0000, 4'b1100);
    expect_beat("sw_hold2", 0, 32'h0000_3000, 32'h3344_0000, 4'b1100);
    mem_ready = 1'b1;
    expect_beat("sw_b0_go", 0, 32'h0000_3000, 32'h3344_0000, 4'b1100);
    expect_beat("sw_b1", 0, 32'h0000_3004, 32'h0000_1122, 4'b0011);
    chk("sw.empty", empty, 1);

    // Fill to DEPTH with memory stalled, fifth request refused
    mem_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_func3 = 3'b010;
      req_addr = 32'h0000_4000 + 32'(4 * i);
      req_data = 32'hA0A0_0000 + 32'(i);
      if (req_ready) acc++;
      tick;
    end
    req_valid = 1'b0;
    chk("full.accepted", acc, 4);
    chk("full.req_ready", req_ready, 0);
    chk("full.count", count, 4);
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++)
      expect_beat($sformatf("full_b%0d", i), 0, 32'h0000_4000 + 32'(4 * i),
                  32'hA0A0_0000 + 32'(i), 4'b1111);
    chk("full.empty", empty, 1);
    chk("full.idle", mem_valid, 0);

    // Reset while beat 1 of a split word is pending
    send(3'b010, 32'h0000_3002, 32'h1122_3344);
    expect_beat("rs_b0", 1, 32'h0000_3000, 32'h3344_0000, 4'b1100);
    chk("rs.b1_valid", mem_valid, 1);
    chk("rs.b1_addr", mem_addr, 32'h0000_3004);
    mem_ready = 1'b0;
    rst = 1'b0;
    tick;
    chk("rs.mem_valid", mem_valid, 0);
    chk("rs.count", count, 0);
    chk("rs.empty", empty, 1);
    rst = 1'b1;
    mem_ready = 1'b1;
    tick; tick;
    chk("rs.after_valid", mem_valid, 0);

    // Illegal funct3 values
    send(3'b011, 32'h0000_5000, 32'h1);
    chk("sd.req_err", req_err, 1);
    chk("sd.count", count, 0);
    tick;
    chk("sd.err_clear", req_err, 0);
    chk("sd.mem_valid", mem_valid, 0);
    send(3'b100, 32'h0000_5000, 32'h1);
    chk("f4.req_err", req_err, 1);
    tick;
    chk("f4.mem_valid", mem_valid, 0);
    chk("f4.empty", empty, 1);

    // No-split instance: crossing store rejected, touching-boundary store accepted
    send_b(3'b010, 32'h0000_3002, 32'h1122_3344);
    chk("ns.req_err", req_err_b, 1);
    chk("ns.count", count_b, 0);
    tick;
    chk("ns.err_clear", req_err_b, 0);
    chk("ns.mem_valid", mem_valid_b, 0);
    send_b(3'b001, 32'h0000_2002, 32'h0000_BEEF);
    chk("ns_sh.req_err", req_err_b, 0);
    tick;
    chk("ns_sh.valid", mem_valid_b, 1);
    chk("ns_sh.addr", mem_addr_b, 32'h0000_2000);
    chk("ns_sh.wdata", mem_wdata_b, 32'hBEEF_0000);
    chk("ns_sh.wmask", mem_wmask_b, 4'b1100);
    tick;
    chk("ns_sh.empty", empty_b, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/store_buffer_unit.md
STORE_BUFFER_UNIT -- requirements
Module: store_buffer_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width; legal values 32 or 64.
REQ-002 SHALL have parameter DEPTH, default 4, number of buffer entries; power of 2, at least 2.
REQ-003 SHALL have parameter MISALIGN_SPLIT, default 1; 1 = split a boundary-crossing store into two beats, 0 = reject it.
REQ-004 SHALL define BYTES = XLEN/8 and OFS = log2(BYTES).
REQ-005 SHALL have clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have rst, input, 1: reset, synchronous and active-low.
REQ-007 SHALL have req_valid, input, 1: store request present.
REQ-008 SHALL have req_ready, output, 1: request can be accepted.
REQ-009 SHALL have req_func3, input, 3: store funct3; 000 SB, 001 SH, 010 SW, 011 SD.
REQ-010 SHALL have req_addr, input, XLEN: byte address.
REQ-011 SHALL have req_data, input, XLEN: register data, right-aligned.
REQ-012 SHALL have mem_valid, output, 1: write beat present.
REQ-013 SHALL have mem_ready, input, 1: memory accepts the beat.
REQ-014 SHALL have mem_addr, output, XLEN: word-aligned address (low OFS bits 0).
REQ-015 SHALL have mem_wdata, output, XLEN: lane-shifted write data.
REQ-016 SHALL have mem_wmask, output, BYTES: byte write enables.
REQ-017 SHALL have req_err, output, 1: one-cycle pulse on a rejected request.
REQ-018 SHALL have empty, output, 1: no entry pending (used for fence/load ordering).
REQ-019 SHALL have count, output, log2(DEPTH)+1: occupied entries.

Function
REQ-020 SHALL accept a request on a rising edge where req_valid and req_ready are both 1.
REQ-021 SHALL drive req_ready = (count != DEPTH), based on registered count only; a same-cycle drain SHALL NOT raise it.
REQ-022 SHALL reject, without enqueueing, funct3[2]=1, or 011 when XLEN=32; it pulses req_err the cycle after acceptance.
REQ-023 With MISALIGN_SPLIT=0, SHALL also reject any store with offset + size > BYTES, the same way (req_err pulse, not enqueued).
REQ-024 SHALL store each accepted legal request in a circular FIFO entry (addr, data, size); head/tail pointers wrap modulo DEPTH.
REQ-025 Lane arithmetic: size = 1 << funct3[1:0]; off = addr[OFS-1:0]; 2*XLEN-wide sdata = zero-extended data[8*size-1:0] << 8*off; 2*BYTES-wide smask = ((1 << size) - 1) << off.
REQ-026 Beat 0 SHALL be: addr with low OFS bits cleared, sdata[XLEN-1:0], smask[BYTES-1:0].
REQ-027 Beat 1 SHALL exist only if smask[2*BYTES-1:BYTES] is nonzero: beat-0 address + BYTES (wraps modulo 2^XLEN), upper halves of sdata and smask.
REQ-028 The drain FSM SHALL have states IDLE, BEAT0, BEAT1.
REQ-029 FSM transitions:
- IDLE to BEAT0 when count > 0.
- BEAT0 to BEAT1 on handshake if beat 1 exists.
- Otherwise, on handshake: to BEAT0 if more entries remain, else IDLE.
- BEAT1 on handshake: to BEAT0 or IDLE by the same rule.
REQ-030 mem_* outputs SHALL be a function of registered state and the head entry only, with no combinational path from req_* to mem_*.
REQ-031 While mem_valid=1 and mem_ready=0, mem_addr, mem_wdata and mem_wmask SHALL hold stable.
REQ-032 SHALL pop the head entry only on the handshake of its final beat.
REQ-033 Latency: a request accepted at edge k into an empty unit SHALL present beat 0 in the cycle following edge k+1 at the latest; aligned back-to-back stores SHALL sustain one beat per cycle.
REQ-034 A simultaneous accept and final-beat pop SHALL leave count unchanged.
REQ-035 SHALL drive empty = (count == 0); mem_valid SHALL be 0 in IDLE.

Reset
REQ-036 On rst=0 at a rising edge SHALL set: count 0, pointers 0, FSM IDLE, mem_valid 0, req_err 0, empty 1.
REQ-037 During reset SHALL drive req_ready 1 (count 0).
REQ-038 Reset mid-operation, including in BEAT1, SHALL discard all entries; no further beat is issued.

Verification
REQ-039 Byte store: XLEN=32, SB addr 0x1003, data 0xAABBCCDD -> single beat: addr 0x1000, wdata 0xDD000000, wmask 1000.
REQ-040 Split halfword: SH addr 0x2003, data 0x1234 -> two beats.
- Beat 0: addr 0x2000, wdata 0x34000000, wmask 1000.
- Beat 1: addr 0x2004, wdata 0x00000012, wmask 0001.
REQ-041 Split word: SW addr 0x3002, data 0x11223344, with mem_ready=0 for 3 cycles then 1.
- Beat 0 held stable while stalled: addr 0x3000, wdata 0x33440000, wmask 1100.
- Then beat 1: addr 0x3004, wdata 0x00001122, wmask 0011.
REQ-042 Full buffer: DEPTH=4, mem_ready=0, 5 consecutive requests -> 4 accepted, req_ready 0, count 4; then mem_ready=1 -> 4 beats in FIFO order, then empty 1.
REQ-043 Reset mid-split: rst=0 while beat 1 of a split SW is pending -> next cycle mem_valid 0, count 0, empty 1.
REQ-044 Rejections, XLEN=32:
- funct3 011 -> req_err pulses once, nothing issued, count stays 0.
- With MISALIGN_SPLIT=0, SW addr 0x3002 -> req_err pulses once, nothing issued.
